// File: rtl/sound_pkg.sv
// Shared types, note tables and helpers for the speaker sound sequencer.
// Frequencies are in Hz as consumed by the tone generator.
package sound_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NOTE,
    GAP
  } state_t;

  typedef enum logic {
    SEQ_FOOD,
    SEQ_OVER
  } seq_t;

  localparam int FOOD_LEN = 3;
  localparam int OVER_LEN = 4;

  localparam logic [31:0] FOOD_NOTES [FOOD_LEN] = '{
    32'd523, 32'd659, 32'd784
  };

  localparam logic [31:0] OVER_NOTES [OVER_LEN] = '{
    32'd392, 32'd330, 32'd262, 32'd196
  };

  function automatic logic [1:0] last_idx(seq_t s);
    return (s == SEQ_OVER) ? 2'(OVER_LEN - 1)
                           : 2'(FOOD_LEN - 1);
  endfunction

  function automatic logic [31:0] note_hz(
    seq_t       s,
    logic [1:0] i
  );
    logic [31:0] hz;
    hz = '0;
    if (s == SEQ_OVER) begin
      hz = OVER_NOTES[i];
    end else if (i < 2'(FOOD_LEN)) begin
      hz = FOOD_NOTES[i];
    end
    return hz;
  endfunction

endpackage

// File: rtl/sound_sequencer_rise_detect.sv
// One-bit rising-edge detector; the history bit resets high so a level
// already asserted at reset release is not mistaken for a new event.
module rise_detect (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prev_q <= 1'b1;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = d & ~prev_q;

endmodule

// File: rtl/sound_sequencer.sv
// Arbitrates food/game-over sound requests and steps the tone generator
// through the chosen jingle with timed notes and silent gaps.
module sound_sequencer
  import sound_pkg::*;
#(
  parameter int NOTE_CYCLES = 5_000_000,
  parameter int GAP_CYCLES  = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        food_eaten,
  input  logic        game_over,
  output logic [31:0] freq,
  output logic        tone_on,
  output logic        busy,
  output logic        done
);

  localparam logic [31:0] NOTE_LAST = 32'(NOTE_CYCLES - 1);
  localparam logic [31:0] GAP_LAST  = 32'(GAP_CYCLES - 1);

  logic food_rise;
  logic over_rise;

  rise_detect u_food_rise (
    .clk   (clk),
    .reset (reset),
    .d     (food_eaten),
    .rise  (food_rise)
  );

  rise_detect u_over_rise (
    .clk   (clk),
    .reset (reset),
    .d     (game_over),
    .rise  (over_rise)
  );

  state_t      state_q, state_d;
  seq_t        seq_q, seq_d;
  logic [1:0]  idx_q, idx_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] freq_q, freq_d;
  logic        tone_q, tone_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic start_over;
  logic start_food;
  logic over_busy;

  // game_over always wins; food cannot interrupt the game-over jingle
  always_comb begin
    over_busy  = (state_q != IDLE) && (seq_q == SEQ_OVER);
    start_over = over_rise;
    start_food = food_rise & ~over_rise & ~over_busy;
  end

  always_comb begin
    state_d = state_q;
    seq_d   = seq_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    unique case (1'b1)
      start_over: begin
        state_d = NOTE;
        seq_d   = SEQ_OVER;
        idx_d   = '0;
        cnt_d   = '0;
      end
      start_food: begin
        state_d = NOTE;
        seq_d   = SEQ_FOOD;
        idx_d   = '0;
        cnt_d   = '0;
      end
      default: begin
        unique case (state_q)
          NOTE: begin
            if (cnt_q == NOTE_LAST) begin
              state_d = GAP;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          GAP: begin
            if (cnt_q == GAP_LAST) begin
              cnt_d = '0;
              if (idx_q == last_idx(seq_q)) begin
                state_d = IDLE;
                idx_d   = '0;
                done_d  = 1'b1;
              end else begin
                state_d = NOTE;
                idx_d   = idx_q + 2'd1;
              end
            end else begin
              cnt_d = cnt_q + 32'd1;
            end
          end
          default: begin
            state_d = IDLE;
          end
        endcase
      end
    endcase
  end

  // outputs are derived from the next state so they align with it
  always_comb begin
    tone_d = (state_d == NOTE);
    busy_d = (state_d != IDLE);
    freq_d = tone_d ? note_hz(seq_d, idx_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      seq_q   <= SEQ_FOOD;
      idx_q   <= '0;
      cnt_q   <= '0;
      freq_q  <= '0;
      tone_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      seq_q   <= seq_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      freq_q  <= freq_d;
      tone_q  <= tone_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign freq    = freq_q;
  assign tone_on = tone_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_sound_sequencer.sv
// Scoreboard bench: a schedule-based model predicts every output cycle,
// a monitor compares the DUT one cycle at a time.
module tb_sound_sequencer;

  localparam int N = 20;
  localparam int G = 10;
  localparam int P = N + G;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        food_eaten = 1'b0;
  logic        game_over = 1'b0;
  logic [31:0] freq;
  logic        tone_on;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  sound_sequencer #(
    .NOTE_CYCLES (N),
    .GAP_CYCLES  (G)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .food_eaten (food_eaten),
    .game_over  (game_over),
    .freq       (freq),
    .tone_on    (tone_on),
    .busy       (busy),
    .done       (done)
  );

  typedef struct packed {
    logic [31:0] freq;
    logic        tone_on;
    logic        busy;
    logic        done;
  } obs_t;

  obs_t exp_q[$];
  obs_t mon_e;
  obs_t mon_a;
  int   vectors = 0;
  int   miscompares = 0;
  int   mon_cyc = 0;

  int food_hz[3] = '{523, 659, 784};
  int over_hz[4] = '{392, 330, 262, 196};

  bit m_active = 1'b0;
  bit m_over = 1'b0;
  int m_start = 0;
  int m_k = 0;
  bit m_pfe = 1'b1;
  bit m_pgo = 1'b1;
  bit lvl_fe = 1'b0;
  bit lvl_go = 1'b0;

  function automatic int seq_len(bit over);
    return over ? 4 : 3;
  endfunction

  function automatic bit busy_at(int k);
    return m_active && (k >= m_start) &&
           ((k - m_start) < seq_len(m_over) * P);
  endfunction

  task automatic cyc(bit r, bit fe, bit go);
    obs_t e;
    bit   fr;
    bit   gr;
    int   off;
    @(negedge clk);
    reset = r;
    food_eaten = fe;
    game_over = go;
    m_k++;
    e = '0;
    if (r) begin
      m_active = 1'b0;
      m_pfe = 1'b1;
      m_pgo = 1'b1;
    end else begin
      gr = go && !m_pgo;
      fr = fe && !m_pfe;
      m_pfe = fe;
      m_pgo = go;
      if (gr) begin
        m_active = 1'b1;
        m_over = 1'b1;
        m_start = m_k;
      end else if (fr && !(busy_at(m_k - 1) && m_over)) begin
        m_active = 1'b1;
        m_over = 1'b0;
        m_start = m_k;
      end
      if (busy_at(m_k)) begin
        off = m_k - m_start;
        e.busy = 1'b1;
        if (off % P < N) begin
          e.tone_on = 1'b1;
          e.freq = m_over ? 32'(over_hz[off / P])
                          : 32'(food_hz[off / P]);
        end
      end
      e.done = m_active &&
               ((m_k - m_start) == seq_len(m_over) * P);
    end
    exp_q.push_back(e);
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) cyc(1'b0, lvl_fe, lvl_go);
  endtask

  task automatic pulse_food();
    lvl_fe = 1'b1;
    run(1);
    lvl_fe = 1'b0;
  endtask

  task automatic pulse_over();
    lvl_go = 1'b1;
    run(1);
    lvl_go = 1'b0;
  endtask

  always @(posedge clk) begin
    #1;
    mon_cyc++;
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {freq, tone_on, busy, done};
      vectors++;
      if (mon_a !== mon_e) begin
        miscompares++;
        if (miscompares <= 20)
          $display("FAIL outputs cyc=%0d got f=%0d t=%0b b=%0b d=%0b exp f=%0d t=%0b b=%0b d=%0b",
                   mon_cyc, mon_a.freq, mon_a.tone_on,
                   mon_a.busy, mon_a.done, mon_e.freq,
                   mon_e.tone_on, mon_e.busy, mon_e.done);
      end
    end
  end

  initial begin
    repeat (3) cyc(1'b1, 1'b0, 1'b0);
    pulse_food();
    run(100);
    pulse_over();
    run(130);
    pulse_food();
    run(29 + int'($urandom_range(0, 19)));
    pulse_over();
    run(140);
    lvl_fe = 1'b1;
    lvl_go = 1'b1;
    run(1);
    lvl_fe = 1'b0;
    lvl_go = 1'b0;
    run(130);
    pulse_over();
    run(5 + int'($urandom_range(0, 95)));
    pulse_food();
    run(140);
    pulse_food();
    run(60 + int'($urandom_range(0, 19)));
    pulse_food();
    run(100);
    pulse_food();
    run(2 + int'($urandom_range(0, 13)));
    lvl_fe = 1'b1;
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    run(20);
    lvl_fe = 1'b0;
    run(3);
    pulse_food();
    run(100);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom % 40 == 0) lvl_fe = ~lvl_fe;
      if ($urandom % 80 == 0) lvl_go = ~lvl_go;
      cyc(($urandom % 600) == 0, lvl_fe, lvl_go);
    end
    @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain left=%0d exp=0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
